axis_pkt_arbiter: RTL and testbench
===================================

// Module: axis_pkt_arbiter
// PURPOSE
//   Packet-granular round-robin arbiter that shares one AXI4-Stream consumer between NUM_REQ byte-stream requesters.
//   Typical consumer: the axis_serialize front end of the I2C bridge.
//   A grant is held from the first beat to the accepted tlast beat, so packets never interleave on the shared serial link.
//   Sits between the command sources (CPU FIFO, autonomous poller, ...) and the serializer.
// PARAMETERS
//   NUM_REQ      2   number of requester ports (>=2)
//   TDATA_WIDTH  8   data width of every stream
//   CNT_WIDTH    16  width of each packet counter (only used with AXIS_ARB_STATS_EN)
// PORTS
//   clk            in   1                      single clock, all logic rising-edge
//   aresetn        in   1                      asynchronous, active-low reset
//   s_axis_tdata   in   NUM_REQ*TDATA_WIDTH    requester data, req i at [i*W +: W]
//   s_axis_tvalid  in   NUM_REQ                per-requester valid
//   s_axis_tlast   in   NUM_REQ                per-requester end of packet
//   s_axis_tready  out  NUM_REQ                per-requester ready
//   m_axis_tdata   out  TDATA_WIDTH            shared output data
//   m_axis_tvalid  out  1                      shared output valid
//   m_axis_tlast   out  1                      shared output last
//   m_axis_tready  in   1                      shared output ready
//   grant_id       out  GRANT_W=$clog2(NUM_REQ) index of current owner
//   busy           out  1                      1 while a packet is owned (PASS)
//   pkt_count      out  NUM_REQ*CNT_WIDTH      completed packets per requester (AXIS_ARB_STATS_EN only)
// BEHAVIOUR
//   Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, grant_id=0, busy=0, state=IDLE.
//   Reset values (cont.): last_grant=NUM_REQ-1, so requester 0 wins first; pkt_count=0.
//   FSM states IDLE and PASS:
//   - IDLE: all s_axis_tready=0; m_axis_tvalid=0.
//     If any s_axis_tvalid=1, the requester chosen by round-robin is registered as grant_id.
//     Round-robin order: first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
//     On that same edge, busy<=1 and state->PASS. Arbitration latency is 1 cycle.
//   - PASS: the datapath is combinational pass-through.
//     m_axis_{tdata,tvalid,tlast} = s_axis_*[grant_id].
//     s_axis_tready[grant_id] = m_axis_tready; all other readys = 0.
//   - Transfer on the master side = m_axis_tvalid & m_axis_tready.
//     A transfer with tlast=1 sets last_grant<=grant_id, busy<=0 and returns to IDLE.
//     This forces exactly one dead cycle between packets.
//   - Requesters never see ready asserted unless they own the grant.
//     A requester that is valid in IDLE but not chosen keeps its data stable (AXIS rule) and waits.
//   - Owner deasserts tvalid mid-packet: grant is held indefinitely, with no timeout and no pre-emption.
//   - Simultaneous tvalid from all requesters over many packets: grants rotate 0,1,..,NUM_REQ-1,0,...
//     Starvation-free; worst-case wait is NUM_REQ-1 packets.
//   - Single-beat packet (tlast on first beat): legal; PASS lasts exactly as long as that beat's handshake.
//   - Reset asserted mid-packet: immediate return to reset values.
//     Partial packet is abandoned; the downstream is reset by the same aresetn.
//   - grant_id is undefined-free: it only changes on an IDLE->PASS transition.
// CONFIGURATION
//   AXIS_ARB_STATS_EN defined:
//   - pkt_count port exists. Counter i increments by 1 on each accepted tlast beat while grant_id==i.
//   - Counters saturate at 2^CNT_WIDTH-1 (no wrap) and are cleared only by aresetn.
//   AXIS_ARB_STATS_EN undefined:
//   - pkt_count port and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Package axis_arb_pkg:
//   - arb_state_t enum {ARB_IDLE, ARB_PASS}
//   - function grant_width(n) returning max(1,$clog2(n))
//   Sub-module axis_rr_picker:
//   - combinational rotate / priority-encode / unrotate
//   - inputs req[NUM_REQ] and last_grant
//   - outputs pick index and any_req
//   Top level holds the FSM, grant register, output mux and optional counters.
// TESTING
//   1. Only req0 sends {AA} (tlast): m_axis beat AA/last=1 one cycle after tvalid; grant_id=0; s_axis_tready[1]=0 throughout.
//   2. req0 {11,22} and req1 {33,44} valid same cycle after reset: output 11,22(last),idle,33,44(last); grant 0 then 1.
//   3. Both always valid, 3 packets each, 1 beat: grant sequence 0,1,0,1,0,1; with STATS_EN pkt_count=3,3.
//   4. m_axis_tready toggled 1010.. during req1 7-byte packet 0F..68: bytes in order, no drops or duplicates, tlast only on 68.
//   5. Owner drops tvalid 5 cycles mid-packet while req0 valid: grant stays on owner; req0 tready=0 until owner's tlast accepted.
//   6. aresetn pulsed low during beat 3 of a 7-beat packet: all outputs at reset values; next grant goes to requester 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream arbiter.
//   arb_state_t  : arbiter FSM state (ARB_IDLE, ARB_PASS)
//   grant_width(): width of a requester index, never below 1 bit
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_t;

  // max(1, clog2(n)) so a grant index always has at least one bit
  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 32'd2) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the
// requester after last_grant sits at bit 0, priority-encode the lowest set
// bit, then rotate the index back.
//   req        : per-requester request (tvalid)
//   last_grant : index of the previous packet owner
//   pick       : first requesting index after last_grant (modulo NUM_REQ)
//   any_req    : at least one request is present
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GRANT_W = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] pick,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int unsigned          start;
  int unsigned          offset;
  int unsigned          sum;

  always_comb begin
    start   = 32'(last_grant) + 32'd1;
    if (start >= NUM_REQ) start = 32'd0;
    // doubled vector makes the rotate a plain right shift
    req_dbl = {req, req};
    req_rot = NUM_REQ'(req_dbl >> start);
    offset  = 32'd0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = 32'(i);
    end
    sum = start + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    pick    = GRANT_W'(sum);
    any_req = |req;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream consumer
// between NUM_REQ requesters. A grant is held from the first beat until the
// tlast beat is accepted, so packets never interleave downstream.
//   clk, aresetn      : clock, asynchronous active-low reset
//   s_axis_*          : requester streams, requester i at [i*W +: W]
//   m_axis_*          : shared output stream (combinational pass-through)
//   grant_id          : index of the current owner (registered)
//   busy              : a packet is owned (registered)
//   pkt_count         : completed packets per requester, saturating
//                       (present only when AXIS_ARB_STATS_EN is defined)
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 2,
  parameter  int unsigned TDATA_WIDTH = 8,
  parameter  int unsigned CNT_WIDTH   = 16,
  localparam int unsigned GRANT_W     = grant_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]             s_axis_tvalid,
  input  logic [NUM_REQ-1:0]             s_axis_tlast,
  output logic [NUM_REQ-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [GRANT_W-1:0]             grant_id,
  output logic                           busy
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]   pkt_count
`endif
);

  arb_state_t         state;
  logic [GRANT_W-1:0] last_grant;
  logic [GRANT_W-1:0] pick;
  logic               any_req;
  logic               xfer_last;

  axis_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_picker (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .pick       (pick),
    .any_req    (any_req)
  );

  // Accepted end-of-packet beat on the shared output
  assign xfer_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Arbitration FSM: grant chosen in IDLE, released on accepted tlast
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      busy       <= 1'b0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (xfer_last) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Pass-through mux; everything is quiet outside PASS
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == ARB_PASS) begin
      m_axis_tdata            = s_axis_tdata[grant_id*TDATA_WIDTH +: TDATA_WIDTH];
      m_axis_tvalid           = s_axis_tvalid[grant_id];
      m_axis_tlast            = s_axis_tlast[grant_id];
      s_axis_tready[grant_id] = m_axis_tready;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  // Per-requester saturating packet counters
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        cnt <= '0;
      end else if (xfer_last && (grant_id == GRANT_W'(g)) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: arbitration table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_axis_pkt_arbiter;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned TDATA_WIDTH = 8;
  localparam int unsigned CNT_WIDTH   = 3;
  localparam int unsigned GRANT_W     = 1;
  localparam int          CNT_MAX     = 7;

  logic clk = 1'b0;
  logic aresetn;
  logic [NUM_REQ*TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_REQ-1:0]             s_axis_tvalid;
  logic [NUM_REQ-1:0]             s_axis_tlast;
  logic [NUM_REQ-1:0]             s_axis_tready;
  logic [TDATA_WIDTH-1:0]         m_axis_tdata;
  logic                           m_axis_tvalid;
  logic                           m_axis_tlast;
  logic                           m_axis_tready;
  logic [GRANT_W-1:0]             grant_id;
  logic                           busy;
`ifdef AXIS_ARB_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0]   pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TDATA_WIDTH (TDATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_id      (grant_id),
    .busy          (busy)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [0:0]  gid;
    logic [15:0] cyc;
  } beat_t;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int                 gid;
  } arb_vec_t;

  logic [8:0] srcq [NUM_REQ][$];
  beat_t      outq[$];
  logic [NUM_REQ-1:0] rdy_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    aresetn = 1'b0;
    idle_inputs();
    m_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    tick();
  endtask

  // Round-robin rule: first valid index after the last owner
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int idx;
      idx = (last + k) % int'(NUM_REQ);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Feed srcq through the arbiter, recording accepted output beats
  task automatic run_src(input int budget, input bit toggle);
    int cyc;
    bit rdy;
    beat_t b;
    cyc = 0;
    rdy = 1'b1;
    outq.delete();
    rdy_seen = '0;
    forever begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (srcq[i].size() > 0) begin
          s_axis_tvalid[i]        = 1'b1;
          s_axis_tdata[i*8 +: 8]  = srcq[i][0][7:0];
          s_axis_tlast[i]         = srcq[i][0][8];
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
      m_axis_tready = toggle ? rdy : 1'b1;
      @(negedge clk);
      rdy_seen = rdy_seen | s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        b.data = m_axis_tdata;
        b.last = m_axis_tlast;
        b.gid  = grant_id;
        b.cyc  = 16'(cyc);
        outq.push_back(b);
      end
      for (int i = 0; i < int'(NUM_REQ); i++)
        if (s_axis_tvalid[i] && s_axis_tready[i]) void'(srcq[i].pop_front());
      cyc++;
      rdy = !rdy;
      tick();
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && !busy) break;
      if (cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL run_src timeout after %0d cycles, required drain", cyc);
        break;
      end
    end
    idle_inputs();
    m_axis_tready = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arb_vec_t vecs[10];
    beat_t exp2[4];
    logic [7:0] bytes4[7];
    logic [NUM_REQ-1:0] vld;
    logic [7:0] dat[NUM_REQ];
    int rem[NUM_REQ];
    int cnt_m[NUM_REQ];
    logic [NUM_REQ-1:0] acc;
    int own, last_own;

    aresetn = 1'b0;
    idle_inputs();
    m_axis_tready = 1'b1;
    #2;
    check("reset_s_tready", s_axis_tready, 0);
    check("reset_m_out", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
    check("reset_grant_busy", {grant_id, busy}, 0);
    @(negedge clk);
    aresetn = 1'b1;
    tick();

    // Arbitration table, single-beat packets, state carried row to row
    vecs[0] = '{2'b01, 0}; vecs[1] = '{2'b11, 1}; vecs[2] = '{2'b11, 0};
    vecs[3] = '{2'b11, 1}; vecs[4] = '{2'b10, 1}; vecs[5] = '{2'b10, 1};
    vecs[6] = '{2'b11, 0}; vecs[7] = '{2'b01, 0}; vecs[8] = '{2'b11, 1};
    vecs[9] = '{2'b10, 1};
    for (int r = 0; r < 10; r++) begin
      s_axis_tvalid = vecs[r].mask;
      s_axis_tlast  = '1;
      for (int i = 0; i < int'(NUM_REQ); i++) s_axis_tdata[i*8 +: 8] = 8'(r*16 + i);
      m_axis_tready = 1'b1;
      @(negedge clk);
      check("tbl_idle", {s_axis_tready, m_axis_tvalid, busy}, 0);
      tick();
      @(negedge clk);
      check("tbl_grant", grant_id, 64'(vecs[r].gid));
      check("tbl_beat", {busy, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
            {1'b1, 1'b1, 1'b1, 8'(r*16 + vecs[r].gid)});
      check("tbl_ready", s_axis_tready, 64'(1 << vecs[r].gid));
      tick();
      idle_inputs();
    end

    // Single beat from requester 0 only
    do_reset();
    srcq[0].push_back(9'h1AA);
    run_src(20, 1'b0);
    check("t1_beats", outq.size(), 1);
    if (outq.size() == 1) check("t1_beat", outq[0], {8'hAA, 1'b1, 1'b0, 16'd1});
    check("t1_ready_seen", rdy_seen, 2'b01);

    // Two requesters valid together: packets back to back with a dead cycle
    do_reset();
    srcq[0].push_back(9'h011); srcq[0].push_back(9'h122);
    srcq[1].push_back(9'h033); srcq[1].push_back(9'h144);
    exp2[0] = {8'h11, 1'b0, 1'b0, 16'd1};
    exp2[1] = {8'h22, 1'b1, 1'b0, 16'd2};
    exp2[2] = {8'h33, 1'b0, 1'b1, 16'd4};
    exp2[3] = {8'h44, 1'b1, 1'b1, 16'd5};
    run_src(30, 1'b0);
    check("t2_beats", outq.size(), 4);
    for (int k = 0; k < 4 && k < outq.size(); k++) check("t2_beat", outq[k], exp2[k]);

    // Both always valid: grants alternate, counts reach 3 each
    do_reset();
    for (int k = 0; k < 3; k++) begin
      srcq[0].push_back(9'(9'h100 + k + 1));
      srcq[1].push_back(9'(9'h110 + k + 1));
    end
    run_src(40, 1'b0);
    check("t3_beats", outq.size(), 6);
    for (int k = 0; k < 6 && k < outq.size(); k++)
      check("t3_seq", {outq[k].gid, outq[k].data, outq[k].last},
            {1'(k % 2), 8'(((k % 2) * 16) + (k / 2) + 1), 1'b1});
`ifdef AXIS_ARB_STATS_EN
    check("t3_pkt_count", pkt_count, {3'd3, 3'd3});
`endif

    // Throttled 7-byte packet from requester 1
    do_reset();
    bytes4 = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h68};
    for (int k = 0; k < 7; k++) srcq[1].push_back({(k == 6), bytes4[k]});
    run_src(40, 1'b1);
    check("t4_beats", outq.size(), 7);
    for (int k = 0; k < 7 && k < outq.size(); k++)
      check("t4_beat", {outq[k].gid, outq[k].last, outq[k].data}, {1'b1, (k == 6), bytes4[k]});

    // Owner stalls mid-packet; waiting requester never sees ready
    do_reset();
    s_axis_tvalid = 2'b10; s_axis_tdata[15:8] = 8'h51; s_axis_tlast = 2'b00;
    tick();
    @(negedge clk);
    check("t5_first", {grant_id, m_axis_tvalid, m_axis_tdata, s_axis_tready}, {1'b1, 1'b1, 8'h51, 2'b10});
    tick();
    s_axis_tvalid = 2'b01; s_axis_tdata[7:0] = 8'h05; s_axis_tlast = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_hold", {busy, grant_id, m_axis_tvalid, s_axis_tready}, {1'b1, 1'b1, 1'b0, 2'b10});
      tick();
    end
    s_axis_tvalid = 2'b11; s_axis_tdata[15:8] = 8'h52; s_axis_tlast = 2'b11;
    @(negedge clk);
    check("t5_last", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready}, {1'b1, 1'b1, 8'h52, 2'b10});
    tick();
    s_axis_tvalid = 2'b01;
    @(negedge clk);
    check("t5_dead", {busy, m_axis_tvalid, s_axis_tready}, 0);
    tick();
    @(negedge clk);
    check("t5_req0", {grant_id, m_axis_tdata, s_axis_tready}, {1'b0, 8'h05, 2'b01});
    tick();
    idle_inputs();
    tick();

    // Reset in the middle of a 7-beat packet
    do_reset();
    s_axis_tvalid = 2'b10; s_axis_tlast = 2'b00; s_axis_tdata[15:8] = 8'h60;
    tick();
    tick(); s_axis_tdata[15:8] = 8'h61;
    tick(); s_axis_tdata[15:8] = 8'h62;
    @(negedge clk);
    check("t6_mid", {busy, grant_id, m_axis_tdata}, {1'b1, 1'b1, 8'h62});
    #1 aresetn = 1'b0;
    #1;
    check("t6_rst_out", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
    check("t6_rst_state", {grant_id, busy}, 0);
    s_axis_tvalid = 2'b11; s_axis_tlast = 2'b01; s_axis_tdata[7:0] = 8'h0A;
    tick();
    aresetn = 1'b1;
    @(negedge clk);
    check("t6_idle", {busy, s_axis_tready}, 0);
    tick();
    @(negedge clk);
    check("t6_regrant", {grant_id, m_axis_tdata, s_axis_tready}, {1'b0, 8'h0A, 2'b01});
    tick();
    idle_inputs();

    // Randomized traffic against the behavioural model
    do_reset();
    vld = '0; acc = '0; own = -1; last_own = int'(NUM_REQ) - 1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rem[i] = 0; dat[i] = 8'h00; cnt_m[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic [NUM_REQ-1:0] exp_rdy;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (acc[i]) begin rem[i]--; vld[i] = 1'b0; end
        if (!vld[i] && $urandom_range(0, 99) < 60) begin
          if (rem[i] == 0) rem[i] = int'($urandom_range(1, 5));
          vld[i] = 1'b1;
          dat[i] = 8'($urandom);
        end
        s_axis_tvalid[i]       = vld[i];
        s_axis_tdata[i*8 +: 8] = dat[i];
        s_axis_tlast[i]        = (rem[i] == 1);
      end
      m_axis_tready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      exp_rdy = '0;
      if (own >= 0) exp_rdy[own] = m_axis_tready;
      check("rnd_ready", s_axis_tready, exp_rdy);
      check("rnd_busy", busy, (own >= 0));
      if (own >= 0) begin
        check("rnd_grant", grant_id, 64'(own));
        check("rnd_mvalid", m_axis_tvalid, vld[own]);
        if (vld[own]) check("rnd_beat", {m_axis_tlast, m_axis_tdata}, {(rem[own] == 1), dat[own]});
      end else begin
        check("rnd_mvalid_idle", m_axis_tvalid, 0);
      end
      acc = vld & exp_rdy;
      if (own < 0) begin
        if (|vld) own = rr_pick(vld, last_own);
      end else if (vld[own] && m_axis_tready && rem[own] == 1) begin
        if (cnt_m[own] < CNT_MAX) cnt_m[own]++;
        last_own = own;
        own = -1;
      end
      tick();
    end
`ifdef AXIS_ARB_STATS_EN
    for (int i = 0; i < int'(NUM_REQ); i++)
      check("rnd_pkt_count", pkt_count[i*CNT_WIDTH +: CNT_WIDTH], 64'(cnt_m[i]));
`endif
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
